// File: rtl/down_timer.sv
// down_timer: loadable down-counting timer with one-shot and auto-reload
// modes, pause via enable, restart via load and abort. done is a one-cycle
// registered pulse on terminal count or on a zero-value load.
module down_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;

  // State and datapath registers; reset is asynchronous so outputs clear
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic: abort beats load, load beats an enabled decrement.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;

    if (abort) begin
      count_d = '0;
      state_d = IDLE;
    end else if (load) begin
      reload_d = load_val;
      mode_d   = auto_reload;
      if (load_val != '0) begin
        count_d = load_val;
        state_d = RUN;
      end else begin
        // A zero load completes immediately rather than starting a run.
        count_d = '0;
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end else if (state_q == RUN && enable) begin
      if (count_q > ONE) begin
        count_d = count_q - ONE;
      end else begin
        // count_q is 1 here: RUN never holds zero, so this is terminal count.
        done_d = 1'b1;
        if (mode_q) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = IDLE;
        end
      end
    end
  end

  assign count = count_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Testbench for down_timer: directed scenarios with hand-computed literal
// expectations plus randomized traffic, all compared every cycle against a
// behavioural model of the timer.
module tb_down_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [3:0] load_val;
  logic       enable;
  logic       auto_reload;
  logic       abort;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: remaining count, running flag, pulse, period, mode.
  int m_count  = 0;
  bit m_busy   = 1'b0;
  bit m_done   = 1'b0;
  int m_period = 0;
  bit m_periodic = 1'b0;

  down_timer #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .load_val(load_val),
    .enable(enable), .auto_reload(auto_reload), .abort(abort),
    .count(count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = 0; m_busy = 0; m_done = 0; m_period = 0; m_periodic = 0;
  endtask

  // One clock edge of the timer's documented behaviour.
  task automatic model_step(input bit ld, input int lv, input bit en,
                            input bit ar, input bit ab);
    m_done = 0;
    if (ab) begin
      m_count = 0; m_busy = 0;
    end else if (ld) begin
      m_period = lv; m_periodic = ar;
      m_count = lv;
      m_busy = (lv != 0);
      m_done = (lv == 0);
    end else if (m_busy && en) begin
      if (m_count == 1) begin
        m_done = 1;
        m_count = m_periodic ? m_period : 0;
        m_busy = m_periodic;
      end else begin
        m_count = m_count - 1;
      end
    end
  endtask

  // Single compare process: DUT against model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_count", int'(count), m_count);
      chk("model_busy", int'(busy), int'(m_busy));
      chk("model_done", int'(done), int'(m_done));
    end
  end

  task automatic cycle(input bit ld, input logic [3:0] lv, input bit en,
                       input bit ar, input bit ab);
    load = ld; load_val = lv; enable = en; auto_reload = ar; abort = ab;
    @(posedge clk);
    model_step(ld, int'(lv), en, ar, ab);
    @(negedge clk);
    $display("cyc t=%0t ld=%0b lv=%0d en=%0b ar=%0b ab=%0b -> count=%0d busy=%0b done=%0b",
             $time, ld, lv, en, ar, ab, count, busy, done);
  endtask

  task automatic tick(input bit en);
    cycle(1'b0, 4'd0, en, 1'b0, 1'b0);
  endtask

  // Assert reset between edges and confirm outputs clear with no clock edge.
  task automatic async_reset(input string name);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk({name, "_count"}, int'(count), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    int k;
    rst_n = 1'b0; load = 0; load_val = 0; enable = 0; auto_reload = 0; abort = 0;
    #3;
    chk("por_count", int'(count), 0);
    chk("por_busy", int'(busy), 0);
    chk("por_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Idle after reset: enable alone does nothing.
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      chk("idle_count", int'(count), 0);
      chk("idle_busy", int'(busy), 0);
    end

    // One-shot 5.
    cycle(1'b1, 4'd5, 1'b1, 1'b0, 1'b0);
    chk("os_load_count", int'(count), 5);
    chk("os_load_busy", int'(busy), 1);
    for (int e = 4; e >= 0; e--) begin
      tick(1'b1);
      chk("os_count", int'(count), e);
      chk("os_done", int'(done), (e == 0) ? 1 : 0);
      chk("os_busy", int'(busy), (e != 0) ? 1 : 0);
    end
    tick(1'b1);
    chk("os_done_drop", int'(done), 0);
    chk("os_hold0", int'(count), 0);

    // Pause: load 3, four disabled cycles while count is 2.
    cycle(1'b1, 4'd3, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    while (!done && cnt < 20) begin
      tick(!(cnt >= 1 && cnt <= 4));
      cnt++;
      if (cnt == 5) chk("pause_hold", int'(count), 2);
    end
    chk("pause_latency", cnt, 7);

    // Auto-reload 3 for three periods.
    cycle(1'b1, 4'd3, 1'b1, 1'b1, 1'b0);
    for (k = 1; k <= 9; k++) begin
      tick(1'b1);
      chk("ar3_done", int'(done), (k % 3 == 0) ? 1 : 0);
      chk("ar3_count", int'(count), (k % 3 == 0) ? 3 : 3 - (k % 3));
      chk("ar3_busy", int'(busy), 1);
    end
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);
    chk("ar3_abort_busy", int'(busy), 0);

    // Auto-reload 1: done every cycle.
    cycle(1'b1, 4'd1, 1'b1, 1'b1, 1'b0);
    for (k = 1; k <= 5; k++) begin
      tick(1'b1);
      chk("ar1_done", int'(done), 1);
      chk("ar1_count", int'(count), 1);
    end
    cycle(1'b0, 4'd0, 1'b1, 1'b0, 1'b1);

    // Restart at count 1, then load together with abort.
    cycle(1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    tick(1'b1);
    chk("rs_pre_count", int'(count), 1);
    cycle(1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
    chk("rs_count", int'(count), 9);
    chk("rs_done", int'(done), 0);
    cycle(1'b1, 4'd6, 1'b1, 1'b0, 1'b1);
    chk("ab_count", int'(count), 0);
    chk("ab_busy", int'(busy), 0);
    chk("ab_done", int'(done), 0);

    // Zero load: single done pulse, never busy.
    cycle(1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("z_done", int'(done), 1);
    chk("z_busy", int'(busy), 0);
    tick(1'b1);
    chk("z_done_drop", int'(done), 0);
    chk("z_busy2", int'(busy), 0);

    // Maximum value 15: exactly 15 cycles, no wrap after 0.
    cycle(1'b1, 4'd15, 1'b1, 1'b0, 1'b0);
    cnt = 0;
    while (!done && cnt < 30) begin
      tick(1'b1);
      cnt++;
    end
    chk("max_latency", cnt, 15);
    for (k = 0; k < 3; k++) begin
      tick(1'b1);
      chk("max_nowrap", int'(count), 0);
    end

    // Reset mid-count at count 5.
    cycle(1'b1, 4'd7, 1'b1, 1'b0, 1'b0);
    tick(1'b1);
    tick(1'b1);
    chk("mr_pre_count", int'(count), 5);
    async_reset("mr");
    for (k = 0; k < 3; k++) begin
      tick(1'b1);
      chk("mr_after_count", int'(count), 0);
      chk("mr_after_busy", int'(busy), 0);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit ld, en, ar, ab;
      logic [3:0] lv;
      ab = ($urandom_range(0, 39) == 0);
      ld = ($urandom_range(0, 11) == 0);
      en = ($urandom_range(0, 3) != 0);
      ar = $urandom_range(0, 1);
      lv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(0, 15));
      cycle(ld, lv, en, ar, ab);
      if ($urandom_range(0, 299) == 0) async_reset("rnd_rst");
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
